std_mem_d1_arbiter: RTL and testbench

- Round-robin arbiter sharing one single-port 1-D memory (combinational read, registered write with one-cycle `done`) between two requesters.
- Each requester uses a go/done-style handshake.
- The arbiter serialises accesses, registers read data, and flags out-of-range addresses instead of forwarding them.
- Sits between two control groups and the memory instance in generated designs.

---
 rtl/std_mem_d1_arbiter.sv | 136 +++++++++++++
 tb/tb_std_mem_d1_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/std_mem_d1_arbiter.sv
// Round-robin arbiter sharing one single-port 1-D memory between two
// go/done requesters; serialises accesses and rejects out-of-range addresses.
module std_mem_d1_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 16,
  parameter int unsigned IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r0_req,
  input  logic                r0_write,
  input  logic [IDX_SIZE-1:0] r0_addr,
  input  logic [WIDTH-1:0]    r0_wdata,
  output logic                r0_done,
  output logic [WIDTH-1:0]    r0_rdata,
  output logic                r0_err,
  input  logic                r1_req,
  input  logic                r1_write,
  input  logic [IDX_SIZE-1:0] r1_addr,
  input  logic [WIDTH-1:0]    r1_wdata,
  output logic                r1_done,
  output logic [WIDTH-1:0]    r1_rdata,
  output logic                r1_err,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_write_data,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_read_data,
  input  logic                mem_done
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, WAIT, RESP} state_t;

  state_t              state, state_n;
  logic                own_q, own_n;
  logic                prio_q, prio_n;
  logic                we_q, we_n;
  logic [IDX_SIZE-1:0] addr_n;
  logic [WIDTH-1:0]    wdata_n;
  logic [1:0]          done_n, err_n;
  logic [WIDTH-1:0]    rdata0_n, rdata1_n;
  logic                gnt;
  logic                g_write;
  logic [IDX_SIZE-1:0] g_addr;
  logic [WIDTH-1:0]    g_wdata;

  // Memory-facing address/data registers double as the latched request.
  always_comb begin
    state_n  = state;
    own_n    = own_q;
    prio_n   = prio_q;
    we_n     = 1'b0;
    addr_n   = '0;
    wdata_n  = '0;
    done_n   = 2'b00;
    err_n    = 2'b00;
    rdata0_n = r0_rdata;
    rdata1_n = r1_rdata;
    gnt      = (r0_req && r1_req) ? prio_q : r1_req;
    g_write  = gnt ? r1_write : r0_write;
    g_addr   = gnt ? r1_addr  : r0_addr;
    g_wdata  = gnt ? r1_wdata : r0_wdata;

    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          own_n = gnt;
          if (32'(g_addr) >= SIZE) begin
            state_n     = RESP;
            done_n[gnt] = 1'b1;
            err_n[gnt]  = 1'b1;
          end else if (g_write) begin
            state_n = WRITE;
            addr_n  = g_addr;
            wdata_n = g_wdata;
            we_n    = 1'b1;
          end else begin
            state_n = READ;
            addr_n  = g_addr;
          end
        end
      end
      READ: begin
        state_n       = RESP;
        done_n[own_q] = 1'b1;
        if (own_q) rdata1_n = mem_read_data;
        else       rdata0_n = mem_read_data;
      end
      WRITE: state_n = WAIT;
      WAIT: begin
        if (mem_done) begin
          state_n       = RESP;
          done_n[own_q] = 1'b1;
        end
      end
      RESP: begin
        prio_n  = ~own_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      own_q          <= 1'b0;
      prio_q         <= 1'b0;
      we_q           <= 1'b0;
      mem_addr0      <= '0;
      mem_write_data <= '0;
      r0_done        <= 1'b0;
      r1_done        <= 1'b0;
      r0_err         <= 1'b0;
      r1_err         <= 1'b0;
      r0_rdata       <= '0;
      r1_rdata       <= '0;
    end else begin
      state          <= state_n;
      own_q          <= own_n;
      prio_q         <= prio_n;
      we_q           <= we_n;
      mem_addr0      <= addr_n;
      mem_write_data <= wdata_n;
      r0_done        <= done_n[0];
      r1_done        <= done_n[1];
      r0_err         <= err_n[0];
      r1_err         <= err_n[1];
      r0_rdata       <= rdata0_n;
      r1_rdata       <= rdata1_n;
    end
  end

  // A reset arriving during WRITE must suppress the write at that same edge.
  assign mem_write_en = we_q & ~reset;

endmodule

// File: tb/tb_std_mem_d1_arbiter.sv
// Self-checking bench for std_mem_d1_arbiter: directed scenarios plus random
// rounds checked against a transaction-level model of memory and arbitration.
module tb_std_mem_d1_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SIZE  = 16;
  localparam int unsigned IDX   = 5;

  logic             clk, reset;
  logic             r0_req, r0_write, r1_req, r1_write;
  logic [IDX-1:0]   r0_addr, r1_addr;
  logic [WIDTH-1:0] r0_wdata, r1_wdata;
  logic             r0_done, r0_err, r1_done, r1_err;
  logic [WIDTH-1:0] r0_rdata, r1_rdata;
  logic [IDX-1:0]   mem_addr0;
  logic [WIDTH-1:0] mem_write_data, mem_read_data;
  logic             mem_write_en, mem_done;

  std_mem_d1_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr0(mem_addr0), .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read_data(mem_read_data), .mem_done(mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Memory instance model: combinational read, write on edge, done after stall_cyc extra cycles.
  logic [WIDTH-1:0] mem_arr [SIZE];
  logic             mem_init;
  int               stall_cyc;
  int               cnt;
  logic             busy;

  assign mem_read_data = (mem_addr0 < 5'd16) ? mem_arr[mem_addr0[3:0]] : '0;

  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
    if (reset) begin
      mem_done <= 1'b0;
      busy     <= 1'b0;
      cnt      <= 0;
    end else begin
      mem_done <= 1'b0;
      if (mem_write_en) begin
        if (mem_addr0 < 5'd16) mem_arr[mem_addr0[3:0]] <= mem_write_data;
        if (stall_cyc == 0) mem_done <= 1'b1;
        else begin
          busy <= 1'b1;
          cnt  <= stall_cyc;
        end
      end else if (busy) begin
        if (cnt == 1) begin
          mem_done <= 1'b1;
          busy     <= 1'b0;
        end
        cnt <= cnt - 1;
      end
    end
  end

  // Reference model state
  logic [31:0] mem_m [16];
  logic [31:0] rdata_m [2];
  int          prio_m;
  bit          wr_s [2];
  logic [4:0]  addr_s [2];
  logic [31:0] wd_s [2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int who, input bit wr, input logic [4:0] a, input logic [31:0] d);
    wr_s[who] = wr; addr_s[who] = a; wd_s[who] = d;
    if (who == 0) begin
      r0_req = 1'b1; r0_write = wr; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = 1'b1; r1_write = wr; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    prio_m = 0; rdata_m[0] = '0; rdata_m[1] = '0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Expects requester `who` to be granted `off` cycles from now and finish after the model latency.
  task automatic serve(input int who, input int off, input bit drop);
    bit oor;
    int lat;
    logic d_own, d_oth, e_own, e_oth;
    logic [31:0] rd_own;
    oor = addr_s[who] >= 5'd16;
    lat = oor ? 1 : (wr_s[who] ? 3 + stall_cyc : 2);
    for (int n = 1; n <= off + lat; n++) begin
      @(posedge clk);
      #1;
      chk("write_en", 32'(mem_write_en), 32'(!oor && wr_s[who] && n == off + 1));
      if (n == off + 1 && !oor) chk("mem_addr0", 32'(mem_addr0), 32'(addr_s[who]));
      if (n < off + lat) begin
        chk("early_done0", 32'(r0_done), 32'd0);
        chk("early_done1", 32'(r1_done), 32'd0);
      end
    end
    if (!oor && !wr_s[who]) rdata_m[who] = mem_m[addr_s[who][3:0]];
    if (!oor && wr_s[who])  mem_m[addr_s[who][3:0]] = wd_s[who];
    d_own  = (who == 1) ? r1_done  : r0_done;
    d_oth  = (who == 1) ? r0_done  : r1_done;
    e_own  = (who == 1) ? r1_err   : r0_err;
    e_oth  = (who == 1) ? r0_err   : r1_err;
    rd_own = (who == 1) ? r1_rdata : r0_rdata;
    chk("done_owner", 32'(d_own), 32'd1);
    chk("done_other", 32'(d_oth), 32'd0);
    chk("err_owner", 32'(e_own), 32'(oor));
    chk("err_other", 32'(e_oth), 32'd0);
    chk("rdata", rd_own, rdata_m[who]);
    prio_m = 1 - who;
    if (drop) begin
      if (who == 0) r0_req = 1'b0;
      else          r1_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int mask, who;
    reset = 1'b1; mem_init = 1'b1; stall_cyc = 0;
    r0_req = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = init_word(i);
    do_reset();
    mem_init = 1'b0;

    chk("rst_r0_done", 32'(r0_done), 32'd0);
    chk("rst_r1_done", 32'(r1_done), 32'd0);
    chk("rst_r0_err", 32'(r0_err), 32'd0);
    chk("rst_r1_err", 32'(r1_err), 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    chk("rst_r1_rdata", r1_rdata, 32'd0);
    chk("rst_we", 32'(mem_write_en), 32'd0);
    chk("rst_addr0", 32'(mem_addr0), 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);

    // r0 write then read back
    set_req(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    serve(0, 0, 1'b1);
    idle();
    set_req(0, 1'b0, 5'd3, 32'd0);
    serve(0, 0, 1'b1);
    chk("readback", r0_rdata, 32'hDEAD_BEEF);
    idle();

    // simultaneous reads after reset: r0 first
    do_reset();
    set_req(0, 1'b0, 5'd1, 32'd0);
    set_req(1, 1'b0, 5'd2, 32'd0);
    serve(0, 0, 1'b1);
    serve(1, 1, 1'b1);
    idle();

    // both hold req: strict alternation over six accesses
    set_req(0, 1'b0, 5'd4, 32'd0);
    set_req(1, 1'b0, 5'd9, 32'd0);
    who = prio_m;
    serve(who, 0, 1'b0);
    for (int k = 1; k < 6; k++) begin
      who = 1 - who;
      serve(who, 1, 1'b0);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    idle();

    // out-of-range write from r1
    set_req(1, 1'b1, 5'd16, 32'h0BAD_0BAD);
    serve(1, 0, 1'b1);
    idle();

    // reset during WRITE abandons the access
    set_req(0, 1'b1, 5'd5, 32'hCAFE_F00D);
    @(posedge clk);
    #1 chk("we_in_write", 32'(mem_write_en), 32'd1);
    reset = 1'b1; r0_req = 1'b0;
    #1 chk("we_gated_by_reset", 32'(mem_write_en), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    prio_m = 0; rdata_m[0] = '0; rdata_m[1] = '0;
    for (int k = 0; k < 3; k++) begin
      chk("no_done_after_reset", 32'(r0_done), 32'd0);
      chk("addr0_after_reset", 32'(mem_addr0), 32'd0);
      idle();
    end
    set_req(0, 1'b0, 5'd5, 32'd0);
    serve(0, 0, 1'b1);
    chk("addr5_unchanged", r0_rdata, init_word(5));
    idle();

    // slow memory: done held low three extra cycles
    stall_cyc = 3;
    set_req(0, 1'b1, 5'd7, 32'h1234_5678);
    serve(0, 0, 1'b1);
    idle();
    stall_cyc = 0;

    // random rounds
    for (int r = 0; r < 40; r++) begin
      mask = int'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++)
        if (mask[i]) set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom);
      if (mask == 3) begin
        who = prio_m;
        serve(who, 0, 1'b1);
        serve(1 - who, 1, 1'b1);
      end else begin
        serve((mask == 2) ? 1 : 0, 0, 1'b1);
      end
      idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
